// File: rtl/cache_pkg.sv
// Shared encodings for the associative data cache: load/store types, FSM states
// and the width helper used for LRU ages and way indices.
package cache_pkg;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } cacheState_e;

  // A direct-mapped cache still needs a 1-bit way index and age field.
  function automatic int ageWidth(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/assoc_data_cache_if.sv
// Pipeline-side and memory-side bus of the data cache. The slave modport is the
// cache; the master modport drives accesses and answers block transfers.
interface assoc_data_cache_if #(
  parameter int BLOCK_BYTES = 16
);
  localparam int OFS = $clog2(BLOCK_BYTES);

  logic [2:0]               read;
  logic [1:0]               write;
  logic [31:0]              address;
  logic [31:0]              writedata;
  logic [31:0]              readdata;
  logic                     busywait;
  logic                     memRead;
  logic                     memWrite;
  logic [31-OFS:0]          memAddress;
  logic [8*BLOCK_BYTES-1:0] memWritedata;
  logic [8*BLOCK_BYTES-1:0] memReaddata;
  logic                     memBusywait;

  modport master (
    output read, write, address, writedata, memReaddata, memBusywait,
    input  readdata, busywait, memRead, memWrite, memAddress, memWritedata
  );

  modport slave (
    input  read, write, address, writedata, memReaddata, memBusywait,
    output readdata, busywait, memRead, memWrite, memAddress, memWritedata
  );

endinterface

// File: rtl/lru_tracker.sv
// Per-set true-LRU ages: a touched way becomes age 0, younger-or-equal ways age
// by one (saturating), so ages settle into a permutation even from all-zero reset.
module lru_tracker
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_touch,
  input  logic [$clog2(SETS)-1:0]     i_touchSet,
  input  logic [ageWidth(WAYS)-1:0]   i_touchWay,
  input  logic [$clog2(SETS)-1:0]     i_querySet,
  output logic [ageWidth(WAYS)-1:0]   o_victim
);

  localparam int AW = ageWidth(WAYS);

  logic [AW-1:0] r_age [SETS][WAYS];
  logic [AW-1:0] w_bestAge;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_age[s][w] <= '0;
        end
      end
    end else if (i_touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == i_touchWay) begin
          r_age[i_touchSet][w] <= '0;
        end else if ((r_age[i_touchSet][w] <= r_age[i_touchSet][i_touchWay]) &&
                     (r_age[i_touchSet][w] < AW'(WAYS - 1))) begin
          r_age[i_touchSet][w] <= r_age[i_touchSet][w] + 1'b1;
        end
      end
    end
  end

  // Oldest way wins; ties resolve to the lowest index.
  always_comb begin
    o_victim  = '0;
    w_bestAge = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_age[i_querySet][w] > w_bestAge) begin
        w_bestAge = r_age[i_querySet][w];
        o_victim  = AW'(w);
      end
    end
  end

endmodule

// File: rtl/assoc_data_cache.sv
// Set-associative write-back, write-allocate data cache with zero-stall hits,
// true-LRU replacement and a four-state miss FSM.
module assoc_data_cache
  import cache_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int SETS        = 8,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  assoc_data_cache_if.slave    io_bus
);

  localparam int OFS  = $clog2(BLOCK_BYTES);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 32 - IDX - OFS;
  localparam int WW   = ageWidth(WAYS);
  localparam int BW   = 8 * BLOCK_BYTES;

  cacheState_e     r_state;
  cacheState_e     w_nextState;
  logic [WAYS-1:0] r_valid [SETS];
  logic [WAYS-1:0] r_dirty [SETS];
  logic [TAGW-1:0] r_tag   [SETS][WAYS];
  logic [BW-1:0]   r_data  [SETS][WAYS];
  logic [BW-1:0]   r_fill;
  logic [WW-1:0]   r_victim;
  logic [31:0]     r_readdata;

  logic [IDX-1:0]  w_idx;
  logic [TAGW-1:0] w_tag;
  logic [OFS-1:0]  w_byteOfs;
  logic [OFS-1:0]  w_halfOfs;
  logic [OFS-1:0]  w_wordOfs;
  logic            w_store;
  logic            w_load;
  logic            w_access;
  logic            w_hit;
  logic [WW-1:0]   w_hitWay;
  logic            w_hitIdle;
  logic            w_loadHit;
  logic            w_storeHit;
  logic [WW-1:0]   w_lruVictim;
  logic [WW-1:0]   w_victimWay;
  logic            w_victimDirty;
  logic            w_touch;
  logic [WW-1:0]   w_touchWay;
  logic [BW-1:0]   w_hitBlock;
  logic [BW-1:0]   w_storeBlock;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_loadValue;

  assign w_idx     = io_bus.address[IDX+OFS-1:OFS];
  assign w_tag     = io_bus.address[31:IDX+OFS];
  assign w_byteOfs = io_bus.address[OFS-1:0];
  assign w_halfOfs = w_byteOfs & ~OFS'(1);
  assign w_wordOfs = w_byteOfs & ~OFS'(3);

  // A store shadows a simultaneous load request.
  assign w_store  = (io_bus.write != ST_NONE);
  assign w_load   = (io_bus.read != LD_NONE) && !w_store;
  assign w_access = w_store || w_load;

  always_comb begin
    w_hit    = 1'b0;
    w_hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit    = 1'b1;
        w_hitWay = WW'(w);
      end
    end
  end

  always_comb begin
    w_victimWay = w_lruVictim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_victimWay = WW'(w);
      end
    end
  end

  assign w_victimDirty = r_valid[w_idx][w_victimWay] && r_dirty[w_idx][w_victimWay];
  assign w_hitIdle     = w_hit && (r_state == IDLE);
  assign w_loadHit     = w_load && w_hitIdle;
  assign w_storeHit    = w_store && w_hitIdle;
  assign w_hitBlock    = r_data[w_idx][w_hitWay];

  assign w_touch    = (w_access && w_hitIdle) || (r_state == UPDATE);
  assign w_touchWay = (r_state == UPDATE) ? r_victim : w_hitWay;

  lru_tracker #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_touch    (w_touch),
    .i_touchSet (w_idx),
    .i_touchWay (w_touchWay),
    .i_querySet (w_idx),
    .o_victim   (w_lruVictim)
  );

  // Half and word lanes ignore the low address bits rather than trapping.
  assign w_word = w_hitBlock[{w_wordOfs, 3'b000} +: 32];
  assign w_byte = w_word[{io_bus.address[1:0], 3'b000} +: 8];
  assign w_half = w_word[{io_bus.address[1], 4'b0000} +: 16];

  always_comb begin
    case (io_bus.read)
      LD_LB:   w_loadValue = {{24{w_byte[7]}}, w_byte};
      LD_LH:   w_loadValue = {{16{w_half[15]}}, w_half};
      LD_LBU:  w_loadValue = {24'd0, w_byte};
      LD_LHU:  w_loadValue = {16'd0, w_half};
      default: w_loadValue = w_word;
    endcase
  end

  always_comb begin
    w_storeBlock = w_hitBlock;
    case (io_bus.write)
      ST_SB:   w_storeBlock[{w_byteOfs, 3'b000} +: 8]  = io_bus.writedata[7:0];
      ST_SH:   w_storeBlock[{w_halfOfs, 3'b000} +: 16] = io_bus.writedata[15:0];
      ST_SW:   w_storeBlock[{w_wordOfs, 3'b000} +: 32] = io_bus.writedata;
      default: ;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (w_access && !w_hit) w_nextState = w_victimDirty ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (!io_bus.memBusywait) w_nextState = ALLOCATE;
      ALLOCATE:  if (!io_bus.memBusywait) w_nextState = UPDATE;
      UPDATE:    w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  assign io_bus.busywait     = w_access && (!w_hit || (r_state != IDLE));
  assign io_bus.readdata     = w_loadHit ? w_loadValue : r_readdata;
  assign io_bus.memRead      = (r_state == ALLOCATE);
  assign io_bus.memWrite     = (r_state == WRITEBACK);
  assign io_bus.memAddress   = (r_state == WRITEBACK) ? {r_tag[w_idx][r_victim], w_idx}
                                                      : io_bus.address[31:OFS];
  assign io_bus.memWritedata = r_data[w_idx][r_victim];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_victim   <= '0;
      r_readdata <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else begin
      r_state <= w_nextState;
      if ((r_state == IDLE) && w_access && !w_hit) r_victim <= w_victimWay;
      if (w_loadHit) r_readdata <= w_loadValue;
      if (w_storeHit) r_dirty[w_idx][w_hitWay] <= 1'b1;
      if (r_state == UPDATE) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
      end
    end
  end

  // Tag/data storage is left uncleared; valid bits alone gate its use.
  always_ff @(posedge i_clk) begin
    if ((r_state == ALLOCATE) && !io_bus.memBusywait) r_fill <= io_bus.memReaddata;
    if (w_storeHit) r_data[w_idx][w_hitWay] <= w_storeBlock;
    if (r_state == UPDATE) begin
      r_data[w_idx][r_victim] <= r_fill;
      r_tag[w_idx][r_victim]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_assoc_data_cache.sv
// Directed bench for assoc_data_cache (2 ways, 8 sets, 16-byte blocks) with a
// behavioural block memory whose response latency is programmable.
module tb_assoc_data_cache;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  assoc_data_cache_if #(.BLOCK_BYTES(16)) bus();

  assoc_data_cache #(
    .WAYS        (2),
    .SETS        (8),
    .BLOCK_BYTES (16)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  logic [127:0] tbMem [256];
  int           memLatency;
  int           busyCnt;
  int           nMemReads;
  int           nMemWrites;
  int           seqNo;
  int           lastWriteSeq;
  int           lastReadSeq;
  int           overlapCnt;
  logic [27:0]  lastWbAddr;
  logic [127:0] lastWbData;
  int           nChecks;
  int           nBad;

  assign bus.memBusywait = (bus.memRead || bus.memWrite) && (busyCnt < memLatency);
  assign bus.memReaddata = tbMem[bus.memAddress[7:0]];

  // Memory holds busy for memLatency cycles, then completes one transfer.
  always @(posedge clk) begin
    if ((bus.memRead || bus.memWrite) && (busyCnt < memLatency)) busyCnt <= busyCnt + 1;
    else busyCnt <= 0;
    if (bus.memWrite && !bus.memBusywait) begin
      nMemWrites   <= nMemWrites + 1;
      seqNo        <= seqNo + 1;
      lastWriteSeq <= seqNo;
      lastWbAddr   <= bus.memAddress;
      lastWbData   <= bus.memWritedata;
    end
    if (bus.memRead && !bus.memBusywait) begin
      nMemReads   <= nMemReads + 1;
      seqNo       <= seqNo + 1;
      lastReadSeq <= seqNo;
    end
  end

  always @(negedge clk) begin
    if (bus.memRead && bus.memWrite) overlapCnt <= overlapCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one access, waits for BUSYWAIT to fall, samples READDATA in the
  // completing cycle and lets that cycle's edge commit before idling the bus.
  task automatic applyStimulus(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output int cycles);
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = addr;
    bus.writedata = wdata;
    cycles        = 0;
    #1;
    while (bus.busywait && (cycles < 40)) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (bus.busywait) checkOutput({tag, "_timeout"}, 128'd1, 128'd0);
    rdata = bus.readdata;
    @(posedge clk);
    #1;
    bus.read  = LD_NONE;
    bus.write = ST_NONE;
  endtask

  initial begin
    logic [31:0] rdata;
    int          cyc;
    int          rdBase;
    int          wrBase;

    nChecks = 0;
    nBad    = 0;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) begin
        tbMem[i][32*k +: 32] = 32'h1000_0000 | (32'(i) << 8) | 32'(k);
      end
    end
    tbMem[4][31:0] = 32'hDDCC_BBAA;
    memLatency    = 0;
    bus.read      = LD_NONE;
    bus.write     = ST_NONE;
    bus.address   = '0;
    bus.writedata = '0;
    rst           = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_readdata", bus.readdata, 0);
    checkOutput("reset_busywait", bus.busywait, 0);
    checkOutput("reset_memread",  bus.memRead, 0);
    checkOutput("reset_memwrite", bus.memWrite, 0);
    rst = 1'b0;
    #1;

    // Cold miss on block 0x4 (set 4, tag 0), clean allocate.
    rdBase = nMemReads;
    applyStimulus("lw40", LD_LW, ST_NONE, 32'h40, 32'h0, rdata, cyc);
    checkOutput("lw40_data",   rdata, 32'hDDCC_BBAA);
    checkOutput("lw40_cycles", cyc, 3);
    checkOutput("lw40_reads",  nMemReads - rdBase, 1);

    // Store then sub-word loads, all hits.
    rdBase = nMemReads;
    wrBase = nMemWrites;
    applyStimulus("sb41", LD_NONE, ST_SB, 32'h41, 32'h80, rdata, cyc);
    checkOutput("sb41_cycles", cyc, 0);
    applyStimulus("lb41", LD_LB, ST_NONE, 32'h41, 32'h0, rdata, cyc);
    checkOutput("lb41_data", rdata, 32'hFFFF_FF80);
    checkOutput("lb41_cycles", cyc, 0);
    applyStimulus("lbu41", LD_LBU, ST_NONE, 32'h41, 32'h0, rdata, cyc);
    checkOutput("lbu41_data", rdata, 32'h0000_0080);
    applyStimulus("lh40", LD_LH, ST_NONE, 32'h40, 32'h0, rdata, cyc);
    checkOutput("lh40_data", rdata, 32'hFFFF_80AA);
    applyStimulus("lhu43", LD_LHU, ST_NONE, 32'h43, 32'h0, rdata, cyc);
    checkOutput("lhu43_data", rdata, 32'h0000_DDCC);
    applyStimulus("lw43", LD_LW, ST_NONE, 32'h43, 32'h0, rdata, cyc);
    checkOutput("lw43_data", rdata, 32'hDDCC_80AA);
    applyStimulus("lw44", LD_LW, ST_NONE, 32'h44, 32'h0, rdata, cyc);
    checkOutput("lw44_data", rdata, 32'h1000_0401);
    checkOutput("hits_no_reads",  nMemReads - rdBase, 0);
    checkOutput("hits_no_writes", nMemWrites - wrBase, 0);

    // LRU: A=0x40 (way0), B=0xC0, touch A, C=0x140 must evict B.
    wrBase = nMemWrites;
    applyStimulus("lwB", LD_LW, ST_NONE, 32'hC0, 32'h0, rdata, cyc);
    checkOutput("lwB_data",   rdata, 32'h1000_0C00);
    checkOutput("lwB_cycles", cyc, 3);
    applyStimulus("touchA", LD_LW, ST_NONE, 32'h40, 32'h0, rdata, cyc);
    checkOutput("touchA_cycles", cyc, 0);
    applyStimulus("lwC", LD_LW, ST_NONE, 32'h140, 32'h0, rdata, cyc);
    checkOutput("lwC_data",   rdata, 32'h1000_1400);
    checkOutput("lwC_cycles", cyc, 3);
    applyStimulus("lwA_again", LD_LW, ST_NONE, 32'h40, 32'h0, rdata, cyc);
    checkOutput("lwA_again_cycles", cyc, 0);
    checkOutput("lwA_again_data",   rdata, 32'hDDCC_80AA);
    applyStimulus("lwB_again", LD_LW, ST_NONE, 32'hC0, 32'h0, rdata, cyc);
    checkOutput("lwB_again_cycles", cyc, 3);
    checkOutput("lru_no_writes", nMemWrites - wrBase, 0);

    // Dirty A is now LRU; D=0x1C0 forces a writeback before the fill.
    rdBase = nMemReads;
    wrBase = nMemWrites;
    applyStimulus("lwD", LD_LW, ST_NONE, 32'h1C0, 32'h0, rdata, cyc);
    checkOutput("lwD_data",   rdata, 32'h1000_1C00);
    checkOutput("lwD_cycles", cyc, 4);
    checkOutput("wb_count",   nMemWrites - wrBase, 1);
    checkOutput("wb_fill",    nMemReads - rdBase, 1);
    checkOutput("wb_before_fill", lastWriteSeq < lastReadSeq, 1);
    checkOutput("wb_addr", lastWbAddr, 28'h000_0004);
    checkOutput("wb_data", lastWbData, 128'h10000403_10000402_10000401_DDCC80AA);

    // Word/half stores and store-over-load priority on block D.
    applyStimulus("swD", LD_NONE, ST_SW, 32'h1C8, 32'hCAFE_F00D, rdata, cyc);
    applyStimulus("shD", LD_NONE, ST_SH, 32'h1CE, 32'h0000_1234, rdata, cyc);
    applyStimulus("lwDc", LD_LW, ST_NONE, 32'h1CC, 32'h0, rdata, cyc);
    checkOutput("lwDc_data", rdata, 32'h1234_1C03);
    applyStimulus("lhuDa", LD_LHU, ST_NONE, 32'h1CA, 32'h0, rdata, cyc);
    checkOutput("lhuDa_data", rdata, 32'h0000_CAFE);
    applyStimulus("lhD8", LD_LH, ST_NONE, 32'h1C8, 32'h0, rdata, cyc);
    checkOutput("lhD8_data", rdata, 32'hFFFF_F00D);
    applyStimulus("both", LD_LW, ST_SB, 32'h1C9, 32'h0000_0077, rdata, cyc);
    checkOutput("both_hold", rdata, 32'hFFFF_F00D);
    applyStimulus("lbuD9", LD_LBU, ST_NONE, 32'h1C9, 32'h0, rdata, cyc);
    checkOutput("lbuD9_data", rdata, 32'h0000_0077);

    // Slow memory: five busy cycles stretch ALLOCATE.
    memLatency = 5;
    rdBase = nMemReads;
    applyStimulus("slow200", LD_LW, ST_NONE, 32'h200, 32'h0, rdata, cyc);
    checkOutput("slow200_cycles", cyc, 8);
    checkOutput("slow200_data",   rdata, 32'h1000_2000);
    checkOutput("slow200_reads",  nMemReads - rdBase, 1);

    // Reset in the middle of ALLOCATE.
    bus.read    = LD_LW;
    bus.address = 32'h300;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("alloc_memread",  bus.memRead, 1);
    checkOutput("alloc_busywait", bus.busywait, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_memread",  bus.memRead, 0);
    checkOutput("rstmid_memwrite", bus.memWrite, 0);
    checkOutput("rstmid_readdata", bus.readdata, 0);
    bus.read = LD_NONE;
    @(negedge clk);
    rst        = 1'b0;
    memLatency = 0;
    @(posedge clk);
    #1;
    rdBase = nMemReads;
    applyStimulus("post300", LD_LW, ST_NONE, 32'h300, 32'h0, rdata, cyc);
    checkOutput("post300_cycles", cyc, 3);
    checkOutput("post300_data",   rdata, 32'h1000_3000);
    applyStimulus("post200", LD_LW, ST_NONE, 32'h200, 32'h0, rdata, cyc);
    checkOutput("post200_cycles", cyc, 3);
    checkOutput("post_reads",     nMemReads - rdBase, 2);

    checkOutput("no_strobe_overlap", overlapCnt, 0);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/assoc_data_cache.md
ASSOC_DATA_CACHE -- requirements
Module: assoc_data_cache

Interface
REQ-001 WAYS, default 2, number of ways per set (power of two, 1..8).
REQ-002 SETS, default 8, number of sets (power of two, 2..64).
REQ-003 BLOCK_BYTES, default 16, bytes per block (power of two, 4..64); OFS=log2(BLOCK_BYTES), IDX=log2(SETS), TAGW=32-IDX-OFS.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 READ  input  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU.
REQ-007 WRITE  input  2  store type: 00 none, 01 SB, 10 SH, 11 SW.
REQ-008 ADDRESS  input  32  byte address of access.
REQ-009 WRITEDATA  input  32  store data, right-aligned.
REQ-010 READDATA  output  32  sign/zero-extended load result.
REQ-011 BUSYWAIT  output  1  stall request to pipeline.
REQ-012 MEM_READ / MEM_WRITE  output  1 each  memory block read/write strobes.
REQ-013 MEM_ADDRESS  output  32-OFS  block address to memory.
REQ-014 MEM_WRITEDATA  output  8*BLOCK_BYTES  victim block for writeback.
REQ-015 MEM_READDATA  input  8*BLOCK_BYTES  fill block from memory.
REQ-016 MEM_BUSYWAIT  input  1  memory busy; transfer complete on first cycle it is low while strobe high.

Function
REQ-017 Access = READ!=0 or WRITE!=0; if both nonzero, store shall take priority and load ignored.
REQ-018 Hit = any way in set ADDRESS[IDX+OFS-1:OFS] valid with tag equal ADDRESS[31:IDX+OFS]; at most one way shall hit.
REQ-019 BUSYWAIT shall be combinational: high when access and (not hit or state!=IDLE), else low; a hit shall complete in the same cycle (zero stall).
REQ-020 Load hit: READDATA combinational from hit way; half/word lanes forced-aligned (ADDRESS[0], ADDRESS[1:0] ignored as needed), little-endian; LB/LH sign-extend, LBU/LHU zero-extend; READDATA holds last value when no load.
REQ-021 Store hit: byte/half/word written into hit way at rising edge, way dirty bit set.
REQ-022 Every hit (load or store) and every fill shall mark that way most-recently-used; true LRU via per-way age counters of log2(WAYS) bits.
REQ-023 Victim on miss: lowest-index invalid way, else LRU way; victim latched at IDLE exit.
REQ-024 FSM states IDLE, WRITEBACK, ALLOCATE, UPDATE.
REQ-025 IDLE -> WRITEBACK on miss with dirty victim; IDLE -> ALLOCATE on miss with clean/invalid victim, for both loads and stores.
REQ-026 WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={victim tag, index}, MEM_WRITEDATA=victim block; -> ALLOCATE when MEM_BUSYWAIT low.
REQ-027 ALLOCATE: MEM_READ=1, MEM_ADDRESS=ADDRESS[31:OFS]; -> UPDATE when MEM_BUSYWAIT low, capturing MEM_READDATA.
REQ-028 UPDATE (one cycle): victim way written with fill data, tag, valid=1, dirty=0; -> IDLE, where the access re-evaluates as a hit.
REQ-029 MEM_READ and MEM_WRITE shall never be high together; both low in IDLE and UPDATE.
REQ-030 ADDRESS, READ, WRITE are held stable by the pipeline while BUSYWAIT high; cache need not tolerate change mid-miss.
REQ-031 Miss latency (clean victim): 1 + memory cycles + 1 UPDATE + hit cycle; dirty adds writeback memory cycles.

Reset
REQ-032 RESET high shall immediately force state IDLE, all valid, dirty bits and age counters to 0, MEM_READ=MEM_WRITE=0, READDATA=0.
REQ-033 Reset mid-miss shall abandon the transfer without partial fill; data arrays are not cleared.

Structure
REQ-034 Package cache_pkg holds load/store encodings, FSM state enum, and LRU age width function.
REQ-035 One sub-module, lru_tracker (per-set age counters, touch and victim outputs), is instantiated once, indexed by set.

Verification
REQ-036 Reset, LW 0x0000_0040 with memory block returning 0x...DDCCBBAA at offset 0 -> one ALLOCATE, then READDATA=0xDDCCBBAA, BUSYWAIT low.
REQ-037 SB 0x80 to 0x0000_0041 after above fill, then LB 0x41 -> READDATA=0xFFFFFF80, LBU -> 0x00000080, no memory traffic.
REQ-038 WAYS=2: fill tags A,B in set 4, touch A, access tag C same set -> B evicted; subsequent A access hits.
REQ-039 Dirty victim: store to way, force eviction -> MEM_WRITE with old tag/index and modified block precedes MEM_READ; never overlapping.
REQ-040 MEM_BUSYWAIT held high 5 cycles in ALLOCATE -> state holds, BUSYWAIT high throughout; RESET pulsed during ALLOCATE -> strobes drop same cycle, later access misses.
